// File: rtl/branch_predictor_update_scheduler_pkg.sv
// rtl/branch_predictor_update_scheduler_pkg.sv - shared types and pc field helpers for the update scheduler
//
// Purpose: branch result / table entry structs, table geometry and the
//          pc -> index / tag extraction used by the scheduler and its queue.
// Ports:   none (package).
package branch_predictor_update_scheduler_pkg;

   localparam int INDEX_W = 9;
   localparam int TAG_W   = 12;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] target_pc;
      logic        taken;
      logic        is_branch;
      logic        is_return;
      logic        is_call;
   } branch_results_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target_pc;
      logic             taken;
      logic             is_branch;
      logic             is_return;
      logic             is_call;
   } btb_update_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } sched_state_t;

   function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] pc);
      return pc[INDEX_W+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] pc);
      return pc[INDEX_W+TAG_W+1:INDEX_W+2];
   endfunction

   function automatic btb_update_entry_t make_entry(input branch_results_t br);
      btb_update_entry_t e;
      e.valid     = 1'b1;
      e.tag       = get_tag(br.pc);
      e.target_pc = br.target_pc;
      e.taken     = br.taken;
      e.is_branch = br.is_branch;
      e.is_return = br.is_return;
      e.is_call   = br.is_call;
      return e;
   endfunction

endpackage

// File: rtl/branch_predictor_update_scheduler_if.sv
// rtl/branch_predictor_update_scheduler_if.sv - bundle of branch-unit, fetch and table-port signals
//
// Purpose: groups every non-clock signal of the scheduler.
// Modports:
//   master - environment side: drives br_results and fetch lookup request/address,
//            observes grant, table port, occupancy and drop pulse.
//   slave  - scheduler side: the mirror of master.
interface branch_predictor_update_scheduler_if #(
   parameter int DEPTH = 4
);
   import branch_predictor_update_scheduler_pkg::*;

   branch_results_t               br_results;
   logic                          fetch_lookup_req;
   logic [INDEX_W-1:0]            fetch_lookup_addr;
   logic                          fetch_grant;
   logic                          table_en;
   logic                          table_we;
   logic [INDEX_W-1:0]            table_addr;
   btb_update_entry_t             table_wdata;
   logic [$clog2(DEPTH+1)-1:0]    queue_count;
   logic                          update_dropped;

   modport master (
      output br_results, fetch_lookup_req, fetch_lookup_addr,
      input  fetch_grant, table_en, table_we, table_addr, table_wdata,
             queue_count, update_dropped
   );

   modport slave (
      input  br_results, fetch_lookup_req, fetch_lookup_addr,
      output fetch_grant, table_en, table_we, table_addr, table_wdata,
             queue_count, update_dropped
   );

endinterface

// File: rtl/branch_predictor_update_scheduler_queue.sv
// rtl/branch_predictor_update_scheduler_queue.sv - circular update buffer with tail overwrite
//
// Purpose: DEPTH-entry FIFO of pending table updates (entry + table index).
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_push             append i_data/i_index at the tail
//   i_overwrite        replace the current tail entry in place (coalesce)
//   i_pop              drop the head entry
//   i_data, i_index    entry and table index to push or overwrite with
//   o_head_data/index  oldest entry
//   o_tail_data/index  newest entry
//   o_count            occupancy 0..DEPTH
module branch_update_queue
   import branch_predictor_update_scheduler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_overwrite,
   input  logic                       i_pop,
   input  btb_update_entry_t          i_data,
   input  logic [INDEX_W-1:0]         i_index,
   output btb_update_entry_t          o_head_data,
   output logic [INDEX_W-1:0]         o_head_index,
   output btb_update_entry_t          o_tail_data,
   output logic [INDEX_W-1:0]         o_tail_index,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   btb_update_entry_t  r_data  [DEPTH];
   logic [INDEX_W-1:0] r_index [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   w_last;

   // r_tail points at the next free slot; the newest entry sits one behind it.
   // DEPTH is a power of two so pointer arithmetic wraps on its own.
   assign w_last = r_tail - PTR_W'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i]  <= '0;
            r_index[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_data[r_tail]  <= i_data;
            r_index[r_tail] <= i_index;
            r_tail          <= r_tail + PTR_W'(1);
         end else if (i_overwrite) begin
            r_data[w_last]  <= i_data;
            r_index[w_last] <= i_index;
         end
         if (i_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_head_data  = r_data[r_head];
   assign o_head_index = r_index[r_head];
   assign o_tail_data  = r_data[w_last];
   assign o_tail_index = r_index[w_last];
   assign o_count      = r_count;

endmodule

// File: rtl/branch_predictor_update_scheduler.sv
// rtl/branch_predictor_update_scheduler.sv - schedules resolved-branch updates into the shared predictor table port
//
// Purpose: buffers branch results, coalesces repeats of the newest entry, and
//          shares the single table port with fetch lookups. Fetch wins unless
//          an update has been denied STARVE_LIMIT cycles in a row, after which
//          one write is forced through.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   io_bus  slave modport: br_results, fetch_lookup_req/addr in;
//           fetch_grant, table_en/we/addr/wdata, queue_count, update_dropped out
module branch_predictor_update_scheduler
   import branch_predictor_update_scheduler_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   branch_predictor_update_scheduler_if.slave   io_bus
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int SC_W  = $clog2(STARVE_LIMIT+1);

   sched_state_t       r_state;
   logic [SC_W-1:0]    r_starve;

   btb_update_entry_t  w_head_data;
   btb_update_entry_t  w_tail_data;
   btb_update_entry_t  w_in_entry;
   logic [INDEX_W-1:0] w_head_index;
   logic [INDEX_W-1:0] w_tail_index;
   logic [INDEX_W-1:0] w_in_index;
   logic [CNT_W-1:0]   w_count;
   logic [CNT_W-1:0]   w_count_next;
   logic               w_empty;
   logic               w_full;
   logic               w_fetch_grant;
   logic               w_write;
   logic               w_match;
   logic               w_coalesce;
   logic               w_push;
   logic               w_drop;

   assign w_in_entry = make_entry(io_bus.br_results);
   assign w_in_index = get_index(io_bus.br_results.pc);
   assign w_empty    = (w_count == '0);
   assign w_full     = (w_count == CNT_W'(DEPTH));

   // Port arbitration: fetch owns the port unless a forced write is due.
   assign w_fetch_grant = io_bus.fetch_lookup_req && (r_state != ST_FORCE);
   assign w_write       = !w_fetch_grant && !w_empty;

   // A single entry being written this cycle is both head and tail; merging
   // into it would lose the newer data, so it is enqueued behind instead.
   assign w_match    = (w_in_index == w_tail_index) && (w_in_entry.tag == w_tail_data.tag);
   assign w_coalesce = io_bus.br_results.valid && !w_empty && w_match &&
                       !((w_count == CNT_W'(1)) && w_write);
   assign w_push     = io_bus.br_results.valid && !w_coalesce && (!w_full || w_write);
   assign w_drop     = io_bus.br_results.valid && !w_coalesce && w_full && !w_write;

   assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_write);

   branch_update_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_push       (w_push),
      .i_overwrite  (w_coalesce),
      .i_pop        (w_write),
      .i_data       (w_in_entry),
      .i_index      (w_in_index),
      .o_head_data  (w_head_data),
      .o_head_index (w_head_index),
      .o_tail_data  (w_tail_data),
      .o_tail_index (w_tail_index),
      .o_count      (w_count)
   );

   // Starvation state machine. The counter only advances while an update is
   // pending and fetch holds the port; reaching STARVE_LIMIT-1 on a denied
   // cycle schedules exactly one forced write.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_EMPTY;
         r_starve <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               r_starve <= '0;
               if (w_push) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_write) begin
                  r_starve <= '0;
                  r_state  <= (w_count_next == '0) ? ST_EMPTY : ST_WAIT;
               end else if (w_fetch_grant) begin
                  if (r_starve == SC_W'(STARVE_LIMIT - 1)) begin
                     r_starve <= '0;
                     r_state  <= ST_FORCE;
                  end else begin
                     r_starve <= r_starve + SC_W'(1);
                  end
               end
            end
            ST_FORCE: begin
               r_starve <= '0;
               r_state  <= (w_count_next == '0) ? ST_EMPTY : ST_WAIT;
            end
            default: begin
               r_starve <= '0;
               r_state  <= ST_EMPTY;
            end
         endcase
      end
   end

   assign io_bus.fetch_grant    = w_fetch_grant;
   assign io_bus.table_en       = w_fetch_grant || w_write;
   assign io_bus.table_we       = w_write;
   assign io_bus.table_addr     = w_fetch_grant ? io_bus.fetch_lookup_addr :
                                  (w_write ? w_head_index : '0);
   assign io_bus.table_wdata    = w_write ? w_head_data : '0;
   assign io_bus.queue_count    = w_count;
   assign io_bus.update_dropped = w_drop;

endmodule
